ddr_pkt_reader: RTL

Parametrised successor to the DDR monitor adaptor.
- Reads one of NUM_BANKS DDR buffer banks over an AXI4 read master, one outstanding burst at a time.
- Packs AXI beats into 512-bit words and emits fixed-size packets with 256-bit metadata to the packet pipeline.
- Controller starts each read with a bank index (generalises odd/even ping-pong) and receives a completion/status handshake.

---
 rtl/ddr_pkt_reader_if.sv | 29 ++
 rtl/ddr_pkt_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_pkt_reader_if.sv
// AXI4 read-address and read-data channels between ddr_pkt_reader (master)
// and the DDR buffer memory (slave).
interface ddr_pkt_reader_if #(
    parameter int AXI_DATA_W = 32
);
    logic                  arid;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic                  rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/ddr_pkt_reader.sv
// Reads one DDR bank as single-outstanding AXI4 INCR bursts, packs beats into 512-bit
// words and emits fixed-size packets with metadata. Define DDR_PKT_SEQNUM_EN for md[199:184] sequence numbers.
module ddr_pkt_reader #(
    parameter int          AXI_DATA_W = 32,
    parameter int          NUM_BANKS  = 2,
    parameter logic [31:0] BANK_BASE  = 32'h0000_0000,
    parameter int          BANK_SIZE  = 1024,
    parameter int          BURST_LEN  = 16,
    parameter int          PKT_WORDS  = 4,
    localparam int         BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              rd_start_valid,
    output logic              rd_start_ready,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              rd_finish_valid,
    input  logic              rd_finish_ready,
    output logic              rd_finish_err,
    output logic [519:0]      pkt_out_data,
    output logic              pkt_out_en,
    output logic [255:0]      pkt_out_md,
    output logic              pkt_out_md_en,
    input  logic              pkt_out_data_alf,
    ddr_pkt_reader_if.master  m_axi
);
    localparam int BEATS_PER_WORD = 512 / AXI_DATA_W;
    localparam int BEAT_W         = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
    localparam int PKT_W          = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int BURST_BYTES    = BURST_LEN * AXI_DATA_W / 8;
    localparam int PKT_LEN_BYTES  = PKT_WORDS * 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t            state_q;
    logic [BANK_W-1:0] bank_q;
    logic [31:0]       addr_q;
    logic [31:0]       end_q;
    logic [31:0]       word_addr_q;
    logic [BEAT_W-1:0] beat_idx_q;
    logic [7:0]        burst_beat_q;
    logic [PKT_W-1:0]  pkt_idx_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [511:0]      asm_q;
    logic [511:0]      word_next;
    logic [15:0]       md_seq;

    logic              start_fire;
    logic              beat_fire;
    logic              word_done;
    logic              head_word;
    logic [BANK_W-1:0] bank_sel;
    logic [31:0]       bank_addr;
    logic [31:0]       addr_inc;

    assign m_axi.arid    = 1'b0;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = 8'(BURST_LEN - 1);
    assign m_axi.arsize  = 3'($clog2(AXI_DATA_W / 8));
    assign m_axi.arburst = 2'b01;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign start_fire = rd_start_valid && rd_start_ready;
    assign beat_fire  = (state_q == S_DATA) && rready_q && m_axi.rvalid;
    assign word_done  = beat_fire && (beat_idx_q == BEAT_W'(BEATS_PER_WORD - 1));
    assign head_word  = (pkt_idx_q == '0);
    assign bank_sel   = BANK_W'(32'(rd_bank) % NUM_BANKS);
    assign bank_addr  = BANK_BASE + 32'(bank_sel) * 32'(BANK_SIZE);
    assign addr_inc   = addr_q + 32'(BURST_BYTES);

    // The beat being accepted is merged in so a completed word can be emitted
    // on the same edge that stores its last beat.
    always_comb begin
        // NOTE: full default before the partial update keeps this purely combinational (no latch).
        word_next = asm_q;
        word_next[beat_idx_q*AXI_DATA_W +: AXI_DATA_W] = m_axi.rdata;
    end

    // NOTE: the assembler is datapath only and every slot is rewritten before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            asm_q <= word_next;
        end
    end

    function automatic logic [1:0] word_flags(input logic [PKT_W-1:0] idx);
        if (PKT_WORDS == 1) return 2'b11;
        if (idx == '0) return 2'b01;
        if (idx == PKT_W'(PKT_WORDS - 1)) return 2'b10;
        return 2'b00;
    endfunction

`ifdef DDR_PKT_SEQNUM_EN
    logic [15:0] seq_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            seq_q <= 16'd0;
        end else if (word_done && head_word) begin
            seq_q <= seq_q + 16'd1;
        end
    end

    assign md_seq = seq_q;
`else
    assign md_seq = 16'd0;
`endif

    // NOTE: all state here updates with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            bank_q          <= '0;
            addr_q          <= 32'd0;
            end_q           <= 32'd0;
            word_addr_q     <= 32'd0;
            beat_idx_q      <= '0;
            burst_beat_q    <= 8'd0;
            pkt_idx_q       <= '0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            rd_start_ready  <= 1'b0;
            rd_finish_valid <= 1'b0;
            rd_finish_err   <= 1'b0;
            pkt_out_data    <= 520'd0;
            pkt_out_en      <= 1'b0;
            pkt_out_md      <= 256'd0;
            pkt_out_md_en   <= 1'b0;
        end else begin
            pkt_out_en    <= 1'b0;
            pkt_out_md_en <= 1'b0;

            if (word_done) begin
                pkt_out_en   <= 1'b1;
                pkt_out_data <= {word_flags(pkt_idx_q), 6'd63, word_next};
                word_addr_q  <= word_addr_q + 32'd64;
                pkt_idx_q    <= (pkt_idx_q == PKT_W'(PKT_WORDS - 1)) ? '0 : pkt_idx_q + 1'b1;
                if (head_word) begin
                    pkt_out_md_en <= 1'b1;
                    pkt_out_md    <= {word_addr_q, 16'(PKT_LEN_BYTES), 8'(bank_q), md_seq, 184'd0};
                end
            end

            case (state_q)
                S_IDLE: begin
                    rd_start_ready <= 1'b1;
                    if (start_fire) begin
                        rd_start_ready <= 1'b0;
                        state_q        <= S_ADDR;
                        bank_q         <= bank_sel;
                        addr_q         <= bank_addr;
                        end_q          <= bank_addr + 32'(BANK_SIZE);
                        word_addr_q    <= bank_addr;
                        rd_finish_err  <= 1'b0;
                        beat_idx_q     <= '0;
                        burst_beat_q   <= 8'd0;
                        pkt_idx_q      <= '0;
                    end
                end

                // Back-pressure only gates raising ARVALID; a raised request is never withdrawn.
                S_ADDR: begin
                    if (!arvalid_q && !pkt_out_data_alf) begin
                        arvalid_q <= 1'b1;
                    end
                    if (arvalid_q && m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (beat_fire) begin
                        beat_idx_q   <= word_done ? '0 : beat_idx_q + 1'b1;
                        burst_beat_q <= burst_beat_q + 8'd1;
                        if (m_axi.rresp != 2'b00) begin
                            rd_finish_err <= 1'b1;
                        end
                        if (m_axi.rlast) begin
                            if (burst_beat_q != 8'(BURST_LEN - 1)) begin
                                rd_finish_err <= 1'b1;
                            end
                            burst_beat_q <= 8'd0;
                            rready_q     <= 1'b0;
                            addr_q       <= addr_inc;
                            state_q      <= (addr_inc == end_q) ? S_DRAIN : S_ADDR;
                        end
                    end
                end

                S_DRAIN: begin
                    rd_finish_valid <= 1'b1;
                    state_q         <= S_FIN;
                end

                S_FIN: begin
                    if (rd_finish_ready) begin
                        rd_finish_valid <= 1'b0;
                        state_q         <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
